// File: rtl/ram_arbiter_if.sv
// CPU-side and RAM-side signal bundle for the two-master RAM arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface ram_arbiter_if #(
    parameter int RAM_AW = 12
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_sel;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              d_err;
    logic              ram_ce;
    logic              ram_we;
    logic [3:0]        ram_sel;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              stall_req;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, ram_rdata,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
               ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, ram_rdata,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
               ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer between instruction fetch and load/store ports
// for one byte-banked RAM: IDLE -> ISSUE (RAM cycle) -> WAIT (ack) -> IDLE.
module ram_arbiter #(
    parameter int RAM_AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_d_q;
    logic              port_d_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [RAM_AW-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       i_rdata_q, d_rdata_q;

    logic              gnt_d;
    logic [31:0]       cmd_addr;
    logic              cmd_err;
    logic              in_issue, in_wait;
    logic [31:0]       rdata_d;

    // Data wins unless instruction is alone or data was granted last.
    always_comb begin
        gnt_d    = bus.d_req & (~bus.i_req | ~last_d_q);
        cmd_addr = gnt_d ? bus.d_addr : bus.i_addr;
        cmd_err  = (|(cmd_addr >> (RAM_AW + 2))) | (~gnt_d & (|cmd_addr[1:0]));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_req | bus.d_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_issue = (state_q == S_ISSUE);
    assign in_wait  = (state_q == S_WAIT);
    assign rdata_d  = (err_q | we_q) ? 32'd0 : bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            last_d_q  <= 1'b0;
            port_d_q  <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            waddr_q   <= '0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && (bus.i_req | bus.d_req)) begin
                port_d_q <= gnt_d;
                last_d_q <= gnt_d;
                we_q     <= gnt_d & bus.d_we;
                sel_q    <= gnt_d ? bus.d_sel : 4'hF;
                waddr_q  <= cmd_addr[RAM_AW+1:2];
                wdata_q  <= gnt_d ? bus.d_wdata : 32'd0;
                err_q    <= cmd_err;
            end
            // Completion value is shown combinationally in WAIT and held afterwards.
            if (in_wait) begin
                if (port_d_q) d_rdata_q <= rdata_d;
                else          i_rdata_q <= rdata_d;
            end
        end
    end

    assign bus.ram_ce    = in_issue & ~err_q;
    assign bus.ram_we    = bus.ram_ce & we_q;
    assign bus.ram_sel   = bus.ram_ce ? sel_q : 4'd0;
    assign bus.ram_addr  = bus.ram_ce ? waddr_q : '0;
    assign bus.ram_wdata = bus.ram_ce ? wdata_q : 32'd0;

    assign bus.i_ack   = in_wait & ~port_d_q;
    assign bus.d_ack   = in_wait & port_d_q;
    assign bus.i_err   = bus.i_ack & err_q;
    assign bus.d_err   = bus.d_ack & err_q;
    assign bus.i_rdata = bus.i_ack ? rdata_d : i_rdata_q;
    assign bus.d_rdata = bus.d_ack ? rdata_d : d_rdata_q;

    assign bus.stall_req = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single accesses against a byte-lane
// RAM model, plus hand sequences for reset, contention and reset mid-access.
module tb_ram_arbiter;
    localparam int AW = 12;

    logic clk;
    logic rst;
    int   n_tot  = 0;
    int   n_pass = 0;

    ram_arbiter_if #(.RAM_AW(AW)) bus ();
    ram_arbiter #(.RAM_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-lane RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) begin
                for (int k = 0; k < 4; k++)
                    if (bus.ram_sel[k]) mem[bus.ram_addr][8*k +: 8] <= bus.ram_wdata[8*k +: 8];
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end
        end
    end

    typedef struct {
        string       name;
        bit          is_i;
        bit          we;
        bit [3:0]    sel;
        bit [31:0]   addr;
        bit [31:0]   wdata;
        bit          exp_err;
        bit [31:0]   exp_rdata;
    } vec_t;

    vec_t tbl [14];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_sel = 0; bus.d_addr = 0; bus.d_wdata = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] ack, oack, err, rd;
        if (v.is_i) begin
            bus.i_req = 1; bus.i_addr = v.addr;
        end else begin
            bus.d_req = 1; bus.d_we = v.we; bus.d_sel = v.sel;
            bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end
        step();  // ISSUE
        chk({v.name, ".ce"}, 32'(bus.ram_ce), 32'(!v.exp_err));
        if (!v.exp_err) begin
            chk({v.name, ".addr"}, 32'(bus.ram_addr), 32'(v.addr[AW+1:2]));
            chk({v.name, ".we"}, 32'(bus.ram_we), 32'(v.we));
            chk({v.name, ".sel"}, 32'(bus.ram_sel), 32'(v.sel));
        end
        chk({v.name, ".noack"}, 32'(bus.i_ack | bus.d_ack), 32'd0);
        chk({v.name, ".stall"}, 32'(bus.stall_req), 32'd1);
        step();  // WAIT
        ack  = v.is_i ? 32'(bus.i_ack) : 32'(bus.d_ack);
        oack = v.is_i ? 32'(bus.d_ack | bus.d_err) : 32'(bus.i_ack | bus.i_err);
        err  = v.is_i ? 32'(bus.i_err) : 32'(bus.d_err);
        rd   = v.is_i ? bus.i_rdata : bus.d_rdata;
        chk({v.name, ".ack"}, ack, 32'd1);
        chk({v.name, ".other"}, oack, 32'd0);
        chk({v.name, ".err"}, err, 32'(v.exp_err));
        chk({v.name, ".rdata"}, rd, v.exp_rdata);
        chk({v.name, ".ce_wait"}, 32'(bus.ram_ce), 32'd0);
        chk({v.name, ".stall_ack"}, 32'(bus.stall_req), 32'd0);
        idle_inputs();
        step();  // IDLE
        rd = v.is_i ? bus.i_rdata : bus.d_rdata;
        chk({v.name, ".ack_off"}, 32'(bus.i_ack | bus.d_ack), 32'd0);
        chk({v.name, ".hold"}, rd, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] dack_log, iack_log;
        tbl[0]  = '{"st_w0",    0, 1, 4'hF, 32'h0000_0000, 32'h4455_6677, 0, 32'h0};
        tbl[1]  = '{"ld_w0",    0, 0, 4'hF, 32'h0000_0000, 32'h0,         0, 32'h4455_6677};
        tbl[2]  = '{"st_byte",  0, 1, 4'h1, 32'h0000_0004, 32'h0000_00FF, 0, 32'h0};
        tbl[3]  = '{"st_half",  0, 1, 4'hC, 32'h0000_0004, 32'hAABB_0000, 0, 32'h0};
        tbl[4]  = '{"ld_w1",    0, 0, 4'hF, 32'h0000_0004, 32'h0,         0, 32'hAABB_00FF};
        tbl[5]  = '{"if_w1",    1, 0, 4'hF, 32'h0000_0004, 32'h0,         0, 32'hAABB_00FF};
        tbl[6]  = '{"st_sel0",  0, 1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[7]  = '{"ld_sel0",  0, 0, 4'hF, 32'h0000_0000, 32'h0,         0, 32'h4455_6677};
        tbl[8]  = '{"st_top",   0, 1, 4'hF, 32'h0000_3FFC, 32'h1234_5678, 0, 32'h0};
        tbl[9]  = '{"if_top",   1, 0, 4'hF, 32'h0000_3FFC, 32'h0,         0, 32'h1234_5678};
        tbl[10] = '{"if_mis",   1, 0, 4'hF, 32'h0000_0002, 32'h0,         1, 32'h0};
        tbl[11] = '{"ld_oor",   0, 0, 4'hF, 32'h8000_0000, 32'h0,         1, 32'h0};
        tbl[12] = '{"ld_edge",  0, 0, 4'hF, 32'h0000_4000, 32'h0,         1, 32'h0};
        tbl[13] = '{"ld_unal",  0, 0, 4'hF, 32'h0000_0006, 32'h0,         0, 32'hAABB_00FF};

        for (int w = 0; w < (1 << AW); w++) mem[w] = 32'd0;
        bus.ram_rdata = 32'd0;
        idle_inputs();

        // Reset state; stall still follows its equation while held in reset.
        rst = 0;
        step();
        step();
        chk("rst.outs", {bus.i_rdata | bus.d_rdata}, 32'd0);
        chk("rst.ram", {bus.ram_wdata[31:4], bus.ram_ce, bus.ram_we, bus.ram_sel[1:0]} |
                       32'(bus.ram_addr) | 32'(bus.ram_sel), 32'd0);
        chk("rst.ack", 32'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}), 32'd0);
        bus.i_req = 1;
        #1;
        chk("rst.stall", 32'(bus.stall_req), 32'd1);
        step();
        chk("rst.ce_hold", 32'(bus.ram_ce), 32'd0);
        bus.i_req = 0;
        rst = 1;
        step();

        for (int t = 0; t < 14; t++) run_vec(tbl[t]);
        chk("mem.w0", mem[0], 32'h4455_6677);
        chk("mem.w1", mem[1], 32'hAABB_00FF);

        // Contention straight after reset: D, I, D, I with both held.
        rst = 0;
        step();
        rst = 1;
        bus.d_req = 1; bus.d_we = 0; bus.d_sel = 4'hF; bus.d_addr = 32'h0;
        bus.i_req = 1; bus.i_addr = 32'h4;
        dack_log = 0; iack_log = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            dack_log[k] = bus.d_ack;
            iack_log[k] = bus.i_ack;
            if (k < 11) chk($sformatf("cont.stall%0d", k), 32'(bus.stall_req), 32'd1);
            if (k == 1) chk("cont.d_rdata", bus.d_rdata, 32'h4455_6677);
            if (k == 4) chk("cont.i_rdata", bus.i_rdata, 32'hAABB_00FF);
            if (k == 10) idle_inputs();
        end
        chk("cont.d_order", 32'(dack_log), 32'b0000_1000_0010);
        chk("cont.i_order", 32'(iack_log), 32'b0100_0001_0000);
        step();
        chk("cont.idle_stall", 32'(bus.stall_req), 32'd0);

        // Reset during ISSUE aborts; the held request then completes normally.
        bus.d_req = 1; bus.d_we = 0; bus.d_sel = 4'hF; bus.d_addr = 32'h4;
        step();
        chk("rma.ce", 32'(bus.ram_ce), 32'd1);
        rst = 0;
        step();
        rst = 1;
        chk("rma.ack", 32'(bus.d_ack), 32'd0);
        chk("rma.ce_off", 32'(bus.ram_ce), 32'd0);
        chk("rma.rdata", bus.d_rdata | bus.i_rdata, 32'd0);
        step();
        chk("rma.re_ce", 32'(bus.ram_ce), 32'd1);
        chk("rma.re_noack", 32'(bus.d_ack), 32'd0);
        step();
        chk("rma.re_ack", 32'(bus.d_ack), 32'd1);
        chk("rma.re_rdata", bus.d_rdata, 32'hAABB_00FF);
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
